// File: rtl/sopc_irq_controller.sv
// sopc_irq_controller
// Avalon-MM interrupt aggregator for up to 16 sources. Sources are
// synchronised to clk, optionally latched on rising edges, masked and
// prioritised (bit 0 highest), and combined into one registered CPU interrupt.
// A saturating counter records edges that arrive on already-pending sources.

module sopc_irq_controller #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  input  logic [N_IRQ-1:0] irq_in,
  output logic [15:0]      readdata,
  output logic             irq_out
);

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_VECTOR  = 3'd3;
  localparam logic [2:0] ADDR_FORCE   = 3'd4;
  localparam logic [2:0] ADDR_RAW     = 3'd5;
  localparam logic [2:0] ADDR_CONTROL = 3'd6;
  localparam logic [2:0] ADDR_OVERRUN = 3'd7;

  // Register state
  logic [N_IRQ-1:0] irqSync_q;
  logic [N_IRQ-1:0] irqDly_q;
  logic [N_IRQ-1:0] epend_q,   epend_d;
  logic [N_IRQ-1:0] enable_q,  enable_d;
  logic [N_IRQ-1:0] mode_q,    mode_d;
  logic             gie_q,     gie_d;
  logic [15:0]      overrun_q, overrun_d;
  logic [15:0]      readdata_q, readdata_d;
  logic             irqOut_q,  irqOut_d;

  // Decoded bus strobes and derived per-source vectors
  logic             wr;
  logic             wrPending;
  logic             wrEnable;
  logic             wrMode;
  logic             wrForce;
  logic             wrControl;
  logic             wrOverrun;
  logic [N_IRQ-1:0] wData;
  logic [N_IRQ-1:0] riseEdge;
  logic [N_IRQ-1:0] pend;
  logic [N_IRQ-1:0] active;
  logic [N_IRQ-1:0] setMask;
  logic [N_IRQ-1:0] clrMask;
  logic             overrunHit;
  logic [3:0]       vecIdx;
  logic [15:0]      vector;

  assign wr        = chipselect & ~write_n;
  assign wrPending = wr & (address == ADDR_PENDING);
  assign wrEnable  = wr & (address == ADDR_ENABLE);
  assign wrMode    = wr & (address == ADDR_MODE);
  assign wrForce   = wr & (address == ADDR_FORCE);
  assign wrControl = wr & (address == ADDR_CONTROL);
  assign wrOverrun = wr & (address == ADDR_OVERRUN);

  // Bits at index N_IRQ and above are simply never looked at.
  assign wData = writedata[N_IRQ-1:0];

  assign riseEdge = irqSync_q & ~irqDly_q;

  // Edge-mode sources report the latch, level-mode sources the synchronised line.
  assign pend   = (mode_q & epend_q) | (~mode_q & irqSync_q);
  assign active = pend & enable_q;

  // A new edge on a source whose latch is still set means an interrupt was lost.
  assign overrunHit = |(riseEdge & mode_q & epend_q);

  // Lowest-numbered active source wins; scanning downward leaves the lowest index.
  always_comb begin
    vecIdx = 4'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        vecIdx = 4'(i);
      end
    end
  end

  assign vector = (|active) ? {1'b1, 11'd0, vecIdx} : 16'h0000;

  // Edge latch next state: a set always beats a clear so no edge is dropped.
  always_comb begin
    setMask = (riseEdge & mode_q) | ({N_IRQ{wrForce}} & wData & mode_q);
    clrMask = ({N_IRQ{wrPending}} & wData) | ({N_IRQ{wrMode}} & ~wData);
    epend_d = setMask | (epend_q & ~clrMask);
  end

  // Configuration registers and the saturating overrun counter.
  always_comb begin
    enable_d  = enable_q;
    mode_d    = mode_q;
    gie_d     = gie_q;
    overrun_d = overrun_q;
    if (wrEnable) begin
      enable_d = wData;
    end
    if (wrMode) begin
      mode_d = wData;
    end
    if (wrControl) begin
      gie_d = writedata[0];
    end
    if (wrOverrun) begin
      overrun_d = 16'h0000;
    end else if (overrunHit && (overrun_q != 16'hFFFF)) begin
      overrun_d = overrun_q + 16'd1;
    end
  end

  // Read mux sampled every cycle from the state held before the edge.
  always_comb begin
    readdata_d = 16'h0000;
    unique case (address)
      ADDR_PENDING: readdata_d = 16'(pend);
      ADDR_ENABLE:  readdata_d = 16'(enable_q);
      ADDR_MODE:    readdata_d = 16'(mode_q);
      ADDR_VECTOR:  readdata_d = vector;
      ADDR_FORCE:   readdata_d = 16'h0000;
      ADDR_RAW:     readdata_d = 16'(irqSync_q);
      ADDR_CONTROL: readdata_d = {15'd0, gie_q};
      ADDR_OVERRUN: readdata_d = overrun_q;
      default:      readdata_d = 16'h0000;
    endcase
    irqOut_d = gie_q & (|active);
  end

  // All state updates at the clock edge; reset discards everything pending.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irqSync_q  <= '0;
      irqDly_q   <= '0;
      epend_q    <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      gie_q      <= 1'b0;
      overrun_q  <= 16'h0000;
      readdata_q <= 16'h0000;
      irqOut_q   <= 1'b0;
    end else begin
      irqSync_q  <= irq_in;
      irqDly_q   <= irqSync_q;
      epend_q    <= epend_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      gie_q      <= gie_d;
      overrun_q  <= overrun_d;
      readdata_q <= readdata_d;
      irqOut_q   <= irqOut_d;
    end
  end

  assign readdata = readdata_q;
  assign irq_out  = irqOut_q;

endmodule

// File: tb/tb_sopc_irq_controller.sv
// Testbench for sopc_irq_controller: directed scenarios plus random traffic,
// each cycle's expected readdata/irq_out pushed to a scoreboard queue by the
// driver and checked by an independent monitor.

module tb_sopc_irq_controller;

   localparam int N = 8;
   localparam logic [15:0] MASK = 16'h00FF;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [N-1:0] irq_in;
   logic [15:0] readdata;
   logic        irq_out;

   int checks = 0;
   int errors = 0;

   logic        rstN;
   logic [15:0] curIrq;

   // Behavioural model state, one 16-bit word per register
   logic [15:0] mSync, mDly, mEp, mEn, mMode, mOv;
   logic        mGie;

   // Each entry is {irq_out, readdata} expected after one clock edge
   logic [16:0] sbQ[$];

   sopc_irq_controller #(.N_IRQ(N)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .irq_in     (irq_in),
      .readdata   (readdata),
      .irq_out    (irq_out)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] modelPend();
      logic [15:0] p;
      p = 16'h0000;
      for (int i = 0; i < N; i++) begin
         p[i] = mMode[i] ? mEp[i] : mSync[i];
      end
      return p;
   endfunction

   function automatic logic [15:0] modelVector(input logic [15:0] act);
      for (int i = 0; i < N; i++) begin
         if (act[i]) return 16'h8000 | 16'(i);
      end
      return 16'h0000;
   endfunction

   // Predict what the DUT shows after the coming edge, then advance the model
   task automatic modelStep(input logic rn, input logic [2:0] a, input logic c,
                            input logic w, input logic [15:0] d, input logic [15:0] irq);
      logic [15:0] pend, act, expRd, wd, newEp;
      logic        wrOn, anyOverrun, rise, setBit, clrBit;
      if (!rn) begin
         sbQ.push_back(17'h0);
         mSync = 0; mDly = 0; mEp = 0; mEn = 0; mMode = 0; mOv = 0; mGie = 0;
         return;
      end
      pend = modelPend();
      act  = pend & mEn;
      case (a)
         3'd0: expRd = pend;
         3'd1: expRd = mEn;
         3'd2: expRd = mMode;
         3'd3: expRd = modelVector(act);
         3'd5: expRd = mSync;
         3'd6: expRd = {15'd0, mGie};
         3'd7: expRd = mOv;
         default: expRd = 16'h0000;
      endcase
      sbQ.push_back({mGie && (act != 0), expRd});
      wrOn = c && !w;
      wd   = d & MASK;
      anyOverrun = 1'b0;
      newEp = mEp;
      for (int i = 0; i < N; i++) begin
         rise   = mSync[i] && !mDly[i];
         if (rise && mMode[i] && mEp[i]) anyOverrun = 1'b1;
         setBit = (rise && mMode[i]) || (wrOn && a == 3'd4 && wd[i] && mMode[i]);
         clrBit = (wrOn && a == 3'd0 && wd[i]) || (wrOn && a == 3'd2 && !wd[i]);
         if (setBit) newEp[i] = 1'b1;
         else if (clrBit) newEp[i] = 1'b0;
      end
      mEp = newEp;
      if (wrOn && a == 3'd7) mOv = 0;
      else if (anyOverrun && mOv != 16'hFFFF) mOv = mOv + 1;
      if (wrOn && a == 3'd1) mEn = wd;
      if (wrOn && a == 3'd2) mMode = wd;
      if (wrOn && a == 3'd6) mGie = d[0];
      mDly  = mSync;
      mSync = irq & MASK;
   endtask

   // Drive one bus cycle at the falling edge and record its expectation
   task automatic applyStimulus(input logic [2:0] a, input logic c, input logic w,
                                input logic [15:0] d);
      @(negedge clk);
      reset_n    = rstN;
      address    = a;
      chipselect = c;
      write_n    = w;
      writedata  = d;
      irq_in     = curIrq[N-1:0];
      modelStep(rstN, a, c, w, d, curIrq);
   endtask

   task automatic wrReg(input logic [2:0] a, input logic [15:0] d);
      applyStimulus(a, 1'b1, 1'b0, d);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(3'd0, 1'b0, 1'b1, 16'h0);
   endtask

   task automatic pulse(input logic [15:0] bits);
      curIrq = bits;
      idle(1);
      curIrq = 16'h0;
      idle(1);
   endtask

   // Read a register and compare against a value taken from the description
   task automatic checkOutput(input string name, input logic [2:0] a,
                              input logic [15:0] expRd, input logic expIrq);
      applyStimulus(a, 1'b0, 1'b1, 16'h0);
      @(posedge clk);
      #2;
      checks++;
      if (readdata !== expRd) begin
         errors++;
         $display("[TB] FAIL %s readdata got %h expected %h", name, readdata, expRd);
      end
      checks++;
      if (irq_out !== expIrq) begin
         errors++;
         $display("[TB] FAIL %s irq_out got %b expected %b", name, irq_out, expIrq);
      end
   endtask

   // Scoreboard monitor: every edge with an expectation queued is checked
   initial begin
      logic [16:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checks++;
            if (readdata !== e[15:0]) begin
               errors++;
               $display("[TB] FAIL sb_readdata at %0t got %h expected %h", $time, readdata, e[15:0]);
            end
            checks++;
            if (irq_out !== e[16]) begin
               errors++;
               $display("[TB] FAIL sb_irq_out at %0t got %b expected %b", $time, irq_out, e[16]);
            end
         end
      end
   end

   // Directed scenarios followed by random traffic
   initial begin
      rstN = 1'b0; curIrq = 16'h00FF;
      mSync = 0; mDly = 0; mEp = 0; mEn = 0; mMode = 0; mOv = 0; mGie = 0;
      reset_n = 1'b0; address = 0; chipselect = 0; write_n = 1; writedata = 0; irq_in = 0;

      idle(3);
      checkOutput("reset_raw", 3'd5, 16'h0000, 1'b0);
      checkOutput("reset_pending", 3'd0, 16'h0000, 1'b0);
      rstN = 1'b1;
      idle(1);
      checkOutput("raw_after_reset", 3'd5, 16'h00FF, 1'b0);
      curIrq = 16'h0;
      idle(3);

      wrReg(3'd2, 16'h00FF);
      wrReg(3'd1, 16'h000C);
      wrReg(3'd6, 16'h0001);
      pulse(16'h0008);
      pulse(16'h0004);
      idle(2);
      checkOutput("edge_pending", 3'd0, 16'h000C, 1'b1);
      checkOutput("edge_vector_2", 3'd3, 16'h8002, 1'b1);
      wrReg(3'd0, 16'h0004);
      checkOutput("edge_vector_3", 3'd3, 16'h8003, 1'b1);
      wrReg(3'd0, 16'h0008);
      checkOutput("edge_vector_none", 3'd3, 16'h0000, 1'b0);

      wrReg(3'd2, 16'h0000);
      wrReg(3'd1, 16'h0001);
      curIrq = 16'h0001;
      idle(1);
      checkOutput("level_raise", 3'd5, 16'h0001, 1'b1);
      wrReg(3'd0, 16'h0001);
      checkOutput("level_pend_write", 3'd0, 16'h0001, 1'b1);
      curIrq = 16'h0;
      idle(1);
      checkOutput("level_drop", 3'd0, 16'h0000, 1'b0);

      wrReg(3'd2, 16'h00FF);
      wrReg(3'd1, 16'h0002);
      wrReg(3'd0, 16'h00FF);
      curIrq = 16'h0002;
      idle(1);
      wrReg(3'd0, 16'h0002);
      curIrq = 16'h0;
      idle(1);
      checkOutput("set_clear_collision", 3'd0, 16'h0002, 1'b1);

      wrReg(3'd7, 16'h0000);
      pulse(16'h0001);
      pulse(16'h0001);
      pulse(16'h0001);
      pulse(16'h0001);
      idle(1);
      checkOutput("overrun_count", 3'd7, 16'h0003, 1'b1);
      wrReg(3'd7, 16'h1234);
      checkOutput("overrun_clear", 3'd7, 16'h0000, 1'b1);

      wrReg(3'd0, 16'h00FF);
      wrReg(3'd1, 16'h0000);
      wrReg(3'd4, 16'h0010);
      checkOutput("force_pending", 3'd0, 16'h0010, 1'b0);
      wrReg(3'd6, 16'h0000);
      wrReg(3'd1, 16'h0010);
      checkOutput("force_gie_off", 3'd3, 16'h8004, 1'b0);
      wrReg(3'd6, 16'h0001);
      checkOutput("force_gie_on", 3'd3, 16'h8004, 1'b1);
      checkOutput("control_read", 3'd6, 16'h0001, 1'b1);

      for (int n = 0; n < 3000; n++) begin
         rstN = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 2) == 0) curIrq = 16'($urandom);
         applyStimulus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 16'($urandom));
      end
      rstN = 1'b1;
      idle(2);
      @(posedge clk);
      #3;
      checks++;
      if (sbQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL sb_drain queue size got %0d expected 0", sbQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
